reg_wr_arbiter: RTL
===================

Name: reg_wr_arbiter

Overview:
- Shares the single 8-bit write path of the CPU register file (eight 8-bit register instances, each with its own write enable) among three requesters: memory load, ALU writeback and 16-bit pair write from the increment/decrement unit.
- Arbitrates and sequences 16-bit pair writes as two byte writes.
- Drives the one-hot write-enable bus and the shared write-data bus into the register file.

Parameters:
- RR_EN, 1, 1 = round-robin arbitration among requesters; 0 = fixed priority MEM > ALU > PAIR.
- FLAG_MASK, 8'hF0, AND mask applied to any byte written to F (index 6).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_m  input  1  memory-load write request.
- sel_m  input  3  target register index for req_m.
- data_m  input  8  write data for req_m.
- req_a  input  1  ALU write request.
- sel_a  input  3  target register index for req_a.
- data_a  input  8  write data for req_a.
- req_p  input  1  16-bit pair write request.
- sel_p  input  2  pair select: 0=BC, 1=DE, 2=HL, 3=AF.
- data_p  input  16  pair data; [15:8] goes to the high register, [7:0] to the low register.
- ack_m  output  1  grant pulse for req_m (combinational).
- ack_a  output  1  grant pulse for req_a (combinational).
- ack_p  output  1  grant pulse for req_p (combinational).
- we  output  8  one-hot register write enables (registered).
- wr  output  8  shared write data (registered).
- busy  output  1  high while a pair write is in progress.

Behaviour:
- Register index map: 0=B, 1=C, 2=D, 3=E, 4=H, 5=L, 6=F, 7=A.
- Pair map:
  - BC = 0/1, DE = 2/3, HL = 4/5, AF = 7/6 (high index/low index).
- Reset (async): state=IDLE, we=0, wr=0, rr_ptr=MEM, busy=0. All acks are 0 while rst is high.
- FSM states: IDLE, PAIR_LO.
- IDLE, arbitration on requests sampled in cycle N:
  - Exactly one winner per cycle, and its ack is high in cycle N.
  - Requester must drop or change req in cycle N+1. A req still high in N+1 is a new request.
  - Single-byte winner (M or A): in cycle N+1, we=one-hot(sel), wr=data. The register file captures at the end of N+1.
  - PAIR winner: no ack in N. In cycle N+1, we=high index, wr=data_p[15:8].
    - data_p[7:0] and the low index are latched internally.
    - State goes to PAIR_LO and busy=1 in N+1.
  - No request: we=0, wr holds its previous value.
- PAIR_LO (one cycle only):
  - No grants; ack_m and ack_a are held 0.
  - ack_p=1 in this cycle.
  - Next cycle: we=low index, wr=latched low byte, state=IDLE, busy=0.
  - req_p must be held until ack_p.
  - Pair write latency: 2 byte cycles after first sample. Second byte lands one cycle after ack_p.
- Round-robin (RR_EN=1):
  - Search order starts at the requester after the last grant, order M -> A -> P -> M.
  - rr_ptr is updated only on a grant. A pair grant updates it when the first byte issues.
- Fixed priority (RR_EN=0): M > A > P. P may starve; that is the caller's responsibility.
- F masking: any byte written to index 6 (single write or AF low byte) goes out as wr = data & FLAG_MASK.
- we is never more than one-hot. wr is don't-care when we=0 but must hold its value.
- sel/data are sampled only in the grant cycle; later changes have no effect.
- Reset mid-pair: the second byte is dropped, no ack_p, and we=0 immediately.
  - The high register keeps its already-written byte; this is accepted.
- Requests arriving during PAIR_LO wait and are arbitrated in the following IDLE cycle. No request is lost while its req is held.

Test Plan:
- Reset, then req_a=1, sel_a=7, data_a=8'h5A -> ack_a high in the same cycle; next cycle we=8'h80, wr=8'h5A; then we=0.
- req_p=1, sel_p=2 (HL), data_p=16'hC0DE -> cycle N+1: we=8'h10, wr=8'hC0, busy=1; cycle N+2: ack_p seen the cycle before, we=8'h20, wr=8'hDE, busy=0.
- req_p, sel_p=3, data_p=16'h12FF -> we=8'h80/wr=8'h12, then we=8'h40/wr=8'hF0 (F masked); also a single write of 8'hBF to index 6 -> wr=8'hB0.
- RR_EN=1: req_m, req_a, req_p all held continuously -> grant order M, A, P (2 cycles), M, A, ...; no requester waits more than 4 cycles.
- RR_EN=0: req_m and req_a high together -> ack_m first, ack_a the next cycle.
- Start a pair on BC, assert rst during PAIR_LO -> we=0, busy=0, no ack_p. B holds the high byte, C is unchanged.

Source files
------------

// File: rtl/reg_wr_arbiter_if.sv
// Write-request bundle between the three register-file writers and the arbiter.
// The arbiter side uses the slave modport; the requesters use master.
interface reg_wr_arbiter_if;
   logic        req_m;
   logic [2:0]  sel_m;
   logic [7:0]  data_m;
   logic        req_a;
   logic [2:0]  sel_a;
   logic [7:0]  data_a;
   logic        req_p;
   logic [1:0]  sel_p;
   logic [15:0] data_p;
   logic        ack_m;
   logic        ack_a;
   logic        ack_p;
   logic [7:0]  we;
   logic [7:0]  wr;
   logic        busy;

   modport slave (
      input  req_m, sel_m, data_m, req_a, sel_a, data_a, req_p, sel_p, data_p,
      output ack_m, ack_a, ack_p, we, wr, busy
   );

   modport master (
      output req_m, sel_m, data_m, req_a, sel_a, data_a, req_p, sel_p, data_p,
      input  ack_m, ack_a, ack_p, we, wr, busy
   );
endinterface

// File: rtl/reg_wr_arbiter.sv
// Arbitrates the shared 8-bit register-file write port among MEM, ALU and 16-bit pair writes.
// Latency: grant in cycle N, byte on we/wr in N+1; pair low byte in N+2. Acks are combinational.
module reg_wr_arbiter #(
   parameter bit         RR_EN     = 1'b1,
   parameter logic [7:0] FLAG_MASK = 8'hF0
) (
   input  logic clk,
   input  logic rst,
   reg_wr_arbiter_if.slave bus
);

   typedef enum logic {IDLE, PAIR_LO} state_t;
   typedef enum logic [1:0] {REQ_M = 2'd0, REQ_A = 2'd1, REQ_P = 2'd2, REQ_NONE = 2'd3} req_t;

   state_t      state_q, state_d;
   req_t        rr_q, rr_d;
   logic [7:0]  we_q, we_d;
   logic [7:0]  wr_q, wr_d;
   logic [2:0]  lo_idx_q, lo_idx_d;
   logic [7:0]  lo_dat_q, lo_dat_d;

   req_t        win;
   logic [2:0]  req_vec;
   logic [1:0]  start;
   logic [2:0]  hi_idx, lo_idx;
   logic        ack_m, ack_a, ack_p;

   function automatic logic [7:0] onehot(input logic [2:0] idx);
      return 8'b1 << idx;
   endfunction

   // F (index 6) only keeps its architected flag bits
   function automatic logic [7:0] fmask(input logic [2:0] idx, input logic [7:0] dat);
      return (idx == 3'd6) ? (dat & FLAG_MASK) : dat;
   endfunction

   assign req_vec = {bus.req_p, bus.req_a, bus.req_m};
   assign start   = RR_EN ? 2'(rr_q) : 2'(REQ_M);
   assign hi_idx  = (bus.sel_p == 2'd3) ? 3'd7 : {bus.sel_p, 1'b0};
   assign lo_idx  = (bus.sel_p == 2'd3) ? 3'd6 : {bus.sel_p, 1'b1};

   always_comb begin
      state_d  = state_q;
      rr_d     = rr_q;
      we_d     = 8'h00;
      wr_d     = wr_q;
      lo_idx_d = lo_idx_q;
      lo_dat_d = lo_dat_q;
      win      = REQ_NONE;
      ack_m    = 1'b0;
      ack_a    = 1'b0;
      ack_p    = 1'b0;

      case (state_q)
         IDLE: begin
            for (int k = 0; k < 3; k++) begin
               int idx;
               idx = (int'(start) + k) % 3;
               if (win == REQ_NONE && req_vec[idx[1:0]]) win = req_t'(idx[1:0]);
            end
            case (win)
               REQ_M: begin
                  ack_m = 1'b1;
                  we_d  = onehot(bus.sel_m);
                  wr_d  = fmask(bus.sel_m, bus.data_m);
               end
               REQ_A: begin
                  ack_a = 1'b1;
                  we_d  = onehot(bus.sel_a);
                  wr_d  = fmask(bus.sel_a, bus.data_a);
               end
               REQ_P: begin
                  // ack_p is deferred to PAIR_LO so the requester keeps data_p stable until then
                  we_d     = onehot(hi_idx);
                  wr_d     = bus.data_p[15:8];
                  lo_idx_d = lo_idx;
                  lo_dat_d = bus.data_p[7:0];
                  state_d  = PAIR_LO;
               end
               default: ;
            endcase
            if (RR_EN && win != REQ_NONE)
               rr_d = (win == REQ_P) ? REQ_M : req_t'(2'(win) + 2'd1);
         end
         PAIR_LO: begin
            ack_p   = 1'b1;
            we_d    = onehot(lo_idx_q);
            wr_d    = fmask(lo_idx_q, lo_dat_q);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         rr_q     <= REQ_M;
         we_q     <= 8'h00;
         wr_q     <= 8'h00;
         lo_idx_q <= 3'd0;
         lo_dat_q <= 8'h00;
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         we_q     <= we_d;
         wr_q     <= wr_d;
         lo_idx_q <= lo_idx_d;
         lo_dat_q <= lo_dat_d;
      end
   end

   assign bus.ack_m = ack_m & ~rst;
   assign bus.ack_a = ack_a & ~rst;
   assign bus.ack_p = ack_p & ~rst;
   assign bus.we    = we_q;
   assign bus.wr    = wr_q;
   assign bus.busy  = (state_q == PAIR_LO);

endmodule
